// File: rtl/mini_src_pkg.sv
// Shared Mini SRC definitions: word width, mul/div opcodes and the MDU state encoding.
`timescale 1ns/1ps
package mini_src_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } mdu_state_t;

endpackage

// File: rtl/mul_div_unit_booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of the multiplicand, then arithmetic shift.
`timescale 1ns/1ps
module booth_step #(
  parameter int unsigned W = 32
) (
  input  logic [W:0]   acc_i,
  input  logic [W-1:0] mq_i,
  input  logic         qm1_i,
  input  logic [W:0]   mcand_i,
  output logic [W:0]   acc_o,
  output logic [W-1:0] mq_o,
  output logic         qm1_o
);

  logic [W:0] sum;

  always_comb begin
    sum = acc_i;
    case ({mq_i[0], qm1_i})
      2'b01:   sum = acc_i + mcand_i;
      2'b10:   sum = acc_i - mcand_i;
      default: sum = acc_i;
    endcase
    // Accumulator carries a guard bit so -2^(W-1) as multiplicand never overflows.
    {acc_o, mq_o, qm1_o} = {sum[W], sum, mq_i};
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply (Booth) / divide (restoring) engine feeding the HI/LO registers.
`timescale 1ns/1ps
module mul_div_unit
  import mini_src_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  mdu_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             op_q, op_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic             qm1_q, qm1_d;
  logic [WIDTH:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             sa_q, sa_d, sb_q, sb_d, dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             dbz_q, dbz_d, done_q, done_d, busy_q, busy_d;

  logic [WIDTH:0]   bacc;
  logic [WIDTH-1:0] bmq;
  logic             bqm1;
  logic [WIDTH:0]   rsh, diff;

  booth_step #(.W(WIDTH)) u_booth (
    .acc_i   (acc_q),
    .mq_i    (mq_q),
    .qm1_i   (qm1_q),
    .mcand_i (mcand_q),
    .acc_o   (bacc),
    .mq_o    (bmq),
    .qm1_o   (bqm1)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    qm1_d   = qm1_q;
    mcand_d = mcand_q;
    a_d     = a_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;
    rsh     = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
    diff    = rsh - mcand_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = CW'(WIDTH - 1);
          op_d    = op;
          acc_d   = '0;
          qm1_d   = 1'b0;
          a_d     = a;
          sa_d    = a[WIDTH-1];
          sb_d    = b[WIDTH-1];
          dz_d    = (b == '0);
          if (op == OP_MUL) begin
            mq_d    = b;
            mcand_d = {a[WIDTH-1], a};
          end else begin
            mq_d    = a[WIDTH-1] ? -a : a;
            mcand_d = {1'b0, (b[WIDTH-1] ? -b : b)};
          end
        end
      end
      RUN: begin
        if (op_q == OP_MUL) begin
          acc_d = bacc;
          mq_d  = bmq;
          qm1_d = bqm1;
        end else begin
          // Restoring step: keep the trial difference only when it did not go negative.
          acc_d = diff[WIDTH] ? rsh : diff;
          mq_d  = {mq_q[WIDTH-2:0], ~diff[WIDTH]};
        end
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      FIX: begin
        state_d = DONE;
        dbz_d   = 1'b0;
        if (op_q == OP_MUL) begin
          hi_d = acc_q[WIDTH-1:0];
          lo_d = mq_q;
        end else if (dz_q) begin
          hi_d  = a_q;
          lo_d  = '1;
          dbz_d = 1'b1;
        end else begin
          hi_d = sa_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          lo_d = (sa_q ^ sb_q) ? -mq_q : mq_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    done_d = (state_d == DONE);
    busy_d = (state_d == RUN) || (state_d == FIX);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      acc_q   <= '0;
      mq_q    <= '0;
      qm1_q   <= 1'b0;
      mcand_q <= '0;
      a_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      qm1_q   <= qm1_d;
      mcand_q <= mcand_d;
      a_q     <= a_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi_out      = hi_q;
  assign lo_out      = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: latency, handshake, multiply/divide vectors and reset abort.
`timescale 1ns/1ps
module tb_mul_div_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          op;
  logic [W-1:0]  a, b;
  logic          busy, done, div_by_zero;
  logic [W-1:0]  hi_out, lo_out;

  int checks = 0;
  int errors = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .hi_out      (hi_out),
    .lo_out      (lo_out),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Drives a one-cycle start pulse; returns just after the sampling edge E0.
  task automatic start_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Observes busy/done in each cycle; a value seen at negedge after E(e-1) is the value at edge Ee.
  task automatic wait_done(input bit inject, output int done_edge, output int done_cnt,
                           output int busy_err);
    done_edge = 0; done_cnt = 0; busy_err = 0;
    for (int e = 1; e <= 40; e++) begin
      @(negedge clk);
      if (inject && e == 5) begin
        start = 1'b1; a = 32'd3; b = 32'd3;
      end
      if (inject && e == 6) start = 1'b0;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_edge == 0) done_edge = e;
      end
      if (busy !== (e <= W + 1)) busy_err++;
      if (done_edge != 0 && e >= done_edge + 1) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (hi_out !== '0) begin errors++; $display("FAIL reset_hi: got %h expected 0", hi_out); end
    checks++; if (lo_out !== '0) begin errors++; $display("FAIL reset_lo: got %h expected 0", lo_out); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
    @(negedge clk) reset = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_mul_basic();
    int de, dc, be;
    start_op(1'b0, 32'd7, 32'hFFFF_FFFD);
    wait_done(1'b0, de, dc, be);
    checks++; if (de !== 34) begin errors++; $display("FAIL mul_latency: done at E%0d expected E34", de); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL mul_done_count: got %0d expected 1", dc); end
    checks++; if (be !== 0) begin errors++; $display("FAIL mul_busy: %0d wrong cycles expected 0", be); end
    checks++; if (hi_out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mul_hi: got %h expected ffffffff", hi_out); end
    checks++; if (lo_out !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_lo: got %h expected ffffffeb", lo_out); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL mul_dbz: got %b expected 0", div_by_zero); end
  endtask

  task automatic test_mul_extremes();
    int de, dc, be;
    start_op(1'b0, 32'h8000_0000, 32'h8000_0000);
    wait_done(1'b0, de, dc, be);
    checks++; if (hi_out !== 32'h4000_0000) begin errors++; $display("FAIL mulmin_hi: got %h expected 40000000", hi_out); end
    checks++; if (lo_out !== 32'h0) begin errors++; $display("FAIL mulmin_lo: got %h expected 0", lo_out); end
    start_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(1'b0, de, dc, be);
    checks++; if (hi_out !== 32'h0) begin errors++; $display("FAIL mulm1_hi: got %h expected 0", hi_out); end
    checks++; if (lo_out !== 32'h1) begin errors++; $display("FAIL mulm1_lo: got %h expected 1", lo_out); end
  endtask

  task automatic test_div_signs();
    int de, dc, be;
    start_op(1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_done(1'b0, de, dc, be);
    checks++; if (de !== 34) begin errors++; $display("FAIL div_latency: done at E%0d expected E34", de); end
    checks++; if (lo_out !== 32'hFFFF_FFFD) begin errors++; $display("FAIL divn_q: got %h expected fffffffd", lo_out); end
    checks++; if (hi_out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divn_r: got %h expected ffffffff", hi_out); end
    start_op(1'b1, 32'd7, 32'hFFFF_FFFE);
    wait_done(1'b0, de, dc, be);
    checks++; if (lo_out !== 32'hFFFF_FFFD) begin errors++; $display("FAIL divd_q: got %h expected fffffffd", lo_out); end
    checks++; if (hi_out !== 32'h1) begin errors++; $display("FAIL divd_r: got %h expected 1", hi_out); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL divd_dbz: got %b expected 0", div_by_zero); end
  endtask

  task automatic test_div_special();
    int de, dc, be;
    start_op(1'b1, 32'd5, 32'd0);
    wait_done(1'b0, de, dc, be);
    checks++; if (de !== 34) begin errors++; $display("FAIL dz_latency: done at E%0d expected E34", de); end
    checks++; if (lo_out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_q: got %h expected ffffffff", lo_out); end
    checks++; if (hi_out !== 32'd5) begin errors++; $display("FAIL dz_r: got %h expected 5", hi_out); end
    checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b expected 1", div_by_zero); end
    repeat (5) @(negedge clk);
    checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_hold: got %b expected 1", div_by_zero); end
    checks++; if (hi_out !== 32'd5) begin errors++; $display("FAIL hi_hold: got %h expected 5", hi_out); end
    start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(1'b0, de, dc, be);
    checks++; if (lo_out !== 32'h8000_0000) begin errors++; $display("FAIL ovf_q: got %h expected 80000000", lo_out); end
    checks++; if (hi_out !== 32'h0) begin errors++; $display("FAIL ovf_r: got %h expected 0", hi_out); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL ovf_dbz: got %b expected 0", div_by_zero); end
  endtask

  task automatic test_handshake();
    int de, dc, be;
    start_op(1'b0, 32'd100, 32'hFFFF_FFFB);
    wait_done(1'b1, de, dc, be);
    checks++; if (dc !== 1) begin errors++; $display("FAIL hs_done_count: got %0d expected 1", dc); end
    checks++; if (de !== 34) begin errors++; $display("FAIL hs_latency: done at E%0d expected E34", de); end
    checks++; if (be !== 0) begin errors++; $display("FAIL hs_busy: %0d wrong cycles expected 0", be); end
    checks++; if (hi_out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL hs_hi: got %h expected ffffffff", hi_out); end
    checks++; if (lo_out !== 32'hFFFF_FE0C) begin errors++; $display("FAIL hs_lo: got %h expected fffffe0c", lo_out); end
    repeat (40) begin
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL hs_extra_done: got %b expected 0", done); end
    end
  endtask

  task automatic test_back_to_back();
    int de, dc, be;
    @(negedge clk);
    op = 1'b0; a = 32'd6; b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 op = 1'b1; a = 32'd100; b = 32'd7;
    wait_done(1'b0, de, dc, be);
    checks++; if (de !== 34) begin errors++; $display("FAIL b2b_first_latency: done at E%0d expected E34", de); end
    checks++; if (lo_out !== 32'd42) begin errors++; $display("FAIL b2b_first_lo: got %h expected 2a", lo_out); end
    checks++; if (hi_out !== 32'd0) begin errors++; $display("FAIL b2b_first_hi: got %h expected 0", hi_out); end
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(1'b0, de, dc, be);
    checks++; if (de !== 34) begin errors++; $display("FAIL b2b_second_latency: done at E%0d expected E34", de); end
    checks++; if (lo_out !== 32'd14) begin errors++; $display("FAIL b2b_second_q: got %h expected e", lo_out); end
    checks++; if (hi_out !== 32'd2) begin errors++; $display("FAIL b2b_second_r: got %h expected 2", hi_out); end
  endtask

  task automatic test_reset_abort();
    int de, dc, be, late;
    start_op(1'b1, 32'h1234, 32'd0);
    wait_done(1'b0, de, dc, be);
    checks++; if (hi_out !== 32'h1234) begin errors++; $display("FAIL ra_preload: got %h expected 1234", hi_out); end
    start_op(1'b0, 32'd3, 32'd4);
    repeat (10) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checks++; if (hi_out !== '0) begin errors++; $display("FAIL ra_hi: got %h expected 0", hi_out); end
    checks++; if (lo_out !== '0) begin errors++; $display("FAIL ra_lo: got %h expected 0", lo_out); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL ra_dbz: got %b expected 0", div_by_zero); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ra_busy: got %b expected 0", busy); end
    @(negedge clk) reset = 1'b1;
    late = 0;
    repeat (50) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) late++;
    end
    checks++; if (late !== 0) begin errors++; $display("FAIL ra_no_done: %0d active cycles expected 0", late); end
    checks++; if (lo_out !== '0) begin errors++; $display("FAIL ra_lo_after: got %h expected 0", lo_out); end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_mul_extremes();
    test_div_signs();
    test_div_special();
    test_handshake();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
